// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory access front-end: default widths,
// FSM state encoding and the buffered command layout.
package mem_ctrl_pkg;

    localparam int MEM_DATA_W = 4;
    localparam int MEM_ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  rw;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module mem_cmd_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = $bits(cmd_t),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) &&
                     (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr[PW-1:0]] <= i_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request front-end for the small memory array: buffers requests,
// replays them in order and returns read data with backpressure.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W     = MEM_DATA_W,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_cmd_t;

    state_t            r_state;
    req_cmd_t          r_cmd;
    logic [DATA_W-1:0] r_rsp_data;
    req_cmd_t          w_head;
    req_cmd_t          w_push_cmd;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_push_cmd = '{rw: req_rw, addr: req_addr, wdata: req_wdata};
    assign w_pop      = (r_state == ST_IDLE);

    mem_cmd_fifo #(
        .WIDTH (1 + ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (req_valid),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_rsp_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cmd   <= w_head;
                        r_state <= w_head.rw ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                ST_READ: begin
                    r_rsp_data <= mem_rdata;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Memory pins decode from registers only so they never glitch
    always_comb begin
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == ST_WRITE) begin
            mem_en    = 1'b1;
            mem_rw    = 1'b1;
            mem_addr  = r_cmd.addr;
            mem_wdata = r_cmd.wdata;
        end else if (r_state == ST_READ) begin
            mem_en   = 1'b1;
            mem_addr = r_cmd.addr;
        end
    end

    assign req_ready = !w_full;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign busy      = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural 4x4 memory.
module tb_mem_access_ctrl;

    typedef struct {
        bit rw;
        int addr;
        int data;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [1:0] req_addr = '0;
    logic [3:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
    logic       mem_en;
    logic       mem_rw;
    logic [1:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;
    logic       busy;

    logic [3:0] mem_arr [4];
    logic [3:0] ref_mem [4];
    acc_t       exp_acc [$];
    int         exp_rsp [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_acc = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    assign mem_rdata = (mem_en && !mem_rw) ? mem_arr[mem_addr] : 4'bz;

    always @(posedge clk) begin
        if (mem_en && mem_rw) mem_arr[mem_addr] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected traffic is derived at acceptance time from a reference memory
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req_valid && req_ready) begin
            acc_t a;
            a.rw   = req_rw;
            a.addr = int'(req_addr);
            a.data = int'(req_wdata);
            exp_acc.push_back(a);
            last_acc = cyc;
            if (req_rw) ref_mem[req_addr] = req_wdata;
            else exp_rsp.push_back(int'(ref_mem[req_addr]));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_en) begin
                if (exp_acc.size() == 0) begin
                    check_eq("acc_unexpected", 32'(mem_en), 32'd0);
                end else begin
                    acc_t e;
                    e = exp_acc.pop_front();
                    check_eq("acc_rw", 32'(mem_rw), 32'(e.rw));
                    check_eq("acc_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.rw) check_eq("acc_wdata", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (rsp_valid) check_eq("no_mem_in_resp", 32'(mem_en), 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    check_eq("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
                end
            end
        end
    end

    task automatic push(input bit rw, input int addr, input int data);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = 2'(addr);
        req_wdata = 4'(data);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) check_eq("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        if (!ok) check_eq("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        #2;
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // single write then read with latency measurement
        push(1'b1, 2, 4'hA);
        wait_idle();
        push(1'b0, 2, 0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = rsp_valid;
            end
            check_eq("rd_seen", 32'(seen), 32'd1);
            check_eq("rd_latency", 32'(cyc - 1 - last_acc), 32'd2);
            check_eq("rd_data_A", 32'(rsp_data), 32'hA);
        end
        wait_idle();

        // fill to full under backpressure
        rsp_ready = 1'b0;
        push(1'b0, 3, 0);
        push(1'b1, 0, 4'h1);
        push(1'b1, 1, 4'h2);
        push(1'b1, 2, 4'h3);
        push(1'b1, 3, 4'h4);
        repeat (3) @(negedge clk);
        check_eq("full_ready", 32'(req_ready), 32'd0);
        check_eq("full_in_resp", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();

        // reset during READ with three commands still queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(1'b0, i % 4, 0);
        @(negedge clk);
        check_eq("full2_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = mem_en && !mem_rw;
            end
            check_eq("reset_read_seen", 32'(seen), 32'd1);
        end
        #1;
        rst_n = 1'b0;
        exp_acc.delete();
        exp_rsp.delete();
        #1;
        check_eq("arst_mem_en", 32'(mem_en), 32'd0);
        check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_rsp_data", 32'(rsp_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("arst_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("no_stale_access", 32'(mem_en | busy), 32'd0);
        end
        @(posedge clk);
        #1;

        // streaming wrap-around of write/read pairs
        for (int i = 0; i < 10; i++) begin
            push(1'b1, i % 4, int'($urandom_range(0, 15)));
            push(1'b0, i % 4, 0);
        end
        wait_idle();

        // push coinciding with the IDLE pop at count 3
        rsp_ready = 1'b0;
        push(1'b0, 1, 0);
        push(1'b1, 0, 4'h5);
        push(1'b1, 1, 4'h6);
        push(1'b1, 2, 4'h7);
        @(negedge clk);
        check_eq("cnt3_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        push(1'b1, 3, 4'h8);
        @(negedge clk);
        check_eq("pushpop_ready", 32'(req_ready), 32'd1);
        push(1'b0, 3, 0);
        wait_idle();

        check_eq("acc_left", 32'(exp_acc.size()), 32'd0);
        check_eq("rsp_left", 32'(exp_rsp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Request front-end that sits directly upstream of the team's 4-word x 4-bit memory array and drives its en/rw/address/data pins. Clients issue write/read requests over a valid/ready handshake. Requests are buffered in a small command FIFO and replayed to the memory strictly in order, one access at a time. Read data is returned over a valid/ready response channel with backpressure.

## Interface
- DATA_W, 4: data width, matches memory word width.
- ADDR_W, 2: address width; the memory holds 2**ADDR_W words.
- FIFO_DEPTH, 4: command FIFO entries; must be a power of two, at least 2.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target word.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_W  read data.
- mem_en  out  1  memory enable.
- mem_rw  out  1  1 = write, 0 = read; meaningful only while mem_en = 1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; may be high-Z while mem_en = 0.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
- Request transfer: a request transfers when req_valid && req_ready at a rising edge. It is pushed as {rw, addr, wdata} into the FIFO.
- req_ready = !fifo_full, from registered state only. There is no combinational path from req_valid.
- FSM states are IDLE, WRITE, READ and RESP.
- IDLE: if the FIFO is non-empty, pop the head into the cmd register. Go to WRITE if cmd.rw = 1, otherwise go to READ. If the FIFO is empty, stay in IDLE.
- WRITE: lasts 1 cycle. Drives mem_en=1, mem_rw=1, mem_addr=cmd.addr, mem_wdata=cmd.wdata. Then goes to IDLE.
- READ: lasts 1 cycle. Drives mem_en=1, mem_rw=0, mem_addr=cmd.addr. At the closing edge it captures mem_rdata into rsp_data, then goes to RESP.
- RESP: rsp_valid=1 and rsp_data is held stable. When rsp_ready=1, go to IDLE.
- mem_* outputs are decoded from the state register and the cmd register only, so they are glitch-free.
- Outside WRITE/READ: mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0.
- Ordering: accesses reach the memory in acceptance order. A read issued after a write to the same address returns the new data.
- FIFO full: req_ready=0, and requests are held off upstream. No request is ever dropped.
- FIFO empty: a push and a pop in the same cycle is impossible. A pop only sees entries written at an earlier edge.
- FIFO push while popping: allowed whenever not full. The count stays unchanged.
- FIFO wrap-around: read and write pointers are ADDR-width counters of log2(FIFO_DEPTH)+1 bits. The extra MSB distinguishes full from empty, and the pointers wrap naturally.
- Backpressure: while in RESP with rsp_ready=0, the FIFO keeps accepting requests until full. No further memory access is issued.
- Reset (rst_n=0, at any time, including mid-access or mid-response):
  - FIFO is emptied and its pointers are zeroed.
  - State goes to IDLE and the cmd register is zeroed.
  - rsp_valid=0, rsp_data=0, busy=0, and all mem_* outputs are 0.
  - req_ready=1 from the first edge after reset is released.
  - Pending commands and responses are discarded.

## Timing
- Accept at edge k, with the FIFO previously empty: the pop happens at edge k+1, and mem_en is high from edge k+1 to edge k+2.
- Write latency: 1 cycle from acceptance to mem_en. Back-to-back writes issue one mem_en pulse every 2 cycles (WRITE, then IDLE).
- Read: data is captured at edge k+2 and rsp_valid is high from edge k+2. The minimum time from acceptance to rsp_valid is 2 cycles.
- Memory contract: mem_rdata is valid combinationally within the cycle where mem_en=1 and mem_rw=0.
- The response handshake completes at the edge where rsp_valid && rsp_ready. The next memory access can begin 1 cycle later at the earliest.
- busy falls in the cycle after the last WRITE/RESP completes with the FIFO empty.

## Structure
- Package mem_ctrl_pkg holds the following:
  - DATA_W and ADDR_W defaults.
  - State enum (IDLE, WRITE, READ, RESP) as a 2-bit typedef.
  - cmd_t packed struct {rw, addr, wdata}.
- Sub-module mem_cmd_fifo: a synchronous FIFO of cmd_t with push, pop, full, empty and head outputs, reset with rst_n.
- Top level: FSM, cmd register, response register and output decode.

## Test plan
- Reset mid-operation: assert rst_n=0 during READ with 3 commands queued. Required response:
  - Outputs zero immediately: mem_en=0, rsp_valid=0, busy=0.
  - req_ready=1 after release.
  - No stale access follows.
- Single write then read: write addr 2 data 4'hA, then read addr 2. Required response:
  - mem_en/mem_rw=1 pulse with mem_addr=2, mem_wdata=A.
  - Read pulse, then rsp_valid with rsp_data=A, 2 cycles after the read is accepted.
- Fill to full under backpressure: hold rsp_ready=0 and push 1 read plus 4 writes. Required response:
  - req_ready drops after the FIFO holds 4 entries.
  - No mem_en while in RESP.
  - After releasing rsp_ready, the 4 writes issue in order.
- Wrap-around: stream 10 alternating write/read pairs to addrs 0..3 cyclically, with rsp_ready=1. Required response:
  - Every response equals the immediately preceding write data.
  - Pointers wrap without loss.
- Simultaneous push/pop at count 3: push while IDLE pops. Required response:
  - Count stays at 3.
  - req_ready stays 1.
  - Order is preserved.
